// File: rtl/norm_pipe_if.sv
// AXI-stream style beat bundle shared by the input and output sides of norm_pipe.
interface norm_pipe_if #(
    parameter int DW = 32,
    parameter int UW = 2
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic [UW-1:0] tuser;
    logic          tlast;

    modport master (output tvalid, tdata, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/norm_pipe.sv
// Per-lane pixel normalisation: multiply by a fixed-point reciprocal, round half up,
// saturate; frame-sequenced by ap_start/cf_ap_done with a two-stage stallable pipeline.
module norm_pipe #(
    parameter int PIXEL_BIT_WIDTH = 16,
    parameter int FRAC_BITS       = 10,
    parameter int LANES           = 2,
    parameter int USER_WIDTH      = 2,
    parameter int CNT_WIDTH       = 24
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       s_axis_resetn,
    input  logic                       ap_start,
    input  logic                       cf_ap_done,
    output logic                       ap_done,
    output logic                       ap_idle,
    input  logic [PIXEL_BIT_WIDTH-1:0] norm_coef,
    input  logic [CNT_WIDTH-1:0]       frame_beats,
    norm_pipe_if.slave                 s_axis,
    norm_pipe_if.master                m_axis,
    output logic                       ovf_sticky
);
    localparam int unsigned W  = PIXEL_BIT_WIDTH;
    localparam int unsigned PW = 2 * W;
    localparam logic [PW:0] HALF  = (PW+1)'(1) << (FRAC_BITS - 1);
    localparam logic [PW:0] LIMIT = (PW+1)'({W{1'b1}});

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_CF = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    logic                   rst;
    logic [1:0]             state;
    logic [W-1:0]           coef_q;
    logic [CNT_WIDTH-1:0]   last_idx;
    logic [CNT_WIDTH-1:0]   in_cnt;
    logic                   s1_valid, s1_last, s2_valid, s2_last;
    logic [USER_WIDTH-1:0]  s1_user, s2_user;
    logic [PW-1:0]          s1_prod [LANES];
    logic [LANES*W-1:0]     s2_data, rnd_data;
    logic                   any_sat;
    logic                   en, in_fire, out_fire, in_is_last;

    assign rst        = srst | ~s_axis_resetn;
    assign en         = !s2_valid || m_axis.tready;
    assign s_axis.tready = (state == ST_RUN) && en;
    assign in_fire    = s_axis.tvalid && s_axis.tready;
    assign out_fire   = s2_valid && m_axis.tready;
    assign in_is_last = (in_cnt == last_idx);

    assign ap_idle       = (state == ST_IDLE);
    assign m_axis.tvalid = s2_valid;
    assign m_axis.tdata  = s2_data;
    assign m_axis.tuser  = s2_user;
    assign m_axis.tlast  = s2_valid && s2_last;

    // Sum is one bit wider than the product so the rounding offset can never wrap.
    always_comb begin : round_sat
        logic [PW:0] sum;
        logic [PW:0] rq;
        sum      = '0;
        rq       = '0;
        rnd_data = '0;
        any_sat  = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            sum = {1'b0, s1_prod[k]} + HALF;
            rq  = sum >> FRAC_BITS;
            if (rq > LIMIT) begin
                rnd_data[k*W +: W] = '1;
                any_sat            = 1'b1;
            end else begin
                rnd_data[k*W +: W] = rq[W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            coef_q     <= '0;
            last_idx   <= '0;
            in_cnt     <= '0;
            ovf_sticky <= 1'b0;
            ap_done    <= 1'b0;
        end else begin
            ap_done <= out_fire && s2_last;
            case (state)
                ST_IDLE: if (ap_start) begin
                    coef_q   <= norm_coef;
                    last_idx <= (frame_beats == '0) ? '0 : frame_beats - 1'b1;
                    in_cnt   <= '0;
                    state    <= cf_ap_done ? ST_RUN : ST_WAIT_CF;
                end
                ST_WAIT_CF: if (cf_ap_done) state <= ST_RUN;
                ST_RUN: if (in_fire) begin
                    if (in_is_last) begin
                        in_cnt <= '0;
                        state  <= ST_DRAIN;
                    end else begin
                        in_cnt <= in_cnt + 1'b1;
                    end
                end
                ST_DRAIN: if (out_fire && s2_last) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (state == ST_IDLE && ap_start)
                ovf_sticky <= 1'b0;
            else if (en && s1_valid && any_sat)
                ovf_sticky <= 1'b1;
        end
    end

    // Last-beat tag rides with the data, so tlast needs no separate output counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_user  <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_user  <= '0;
            s2_data  <= '0;
            for (int unsigned k = 0; k < LANES; k++) s1_prod[k] <= '0;
        end else if (en) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                for (int unsigned k = 0; k < LANES; k++)
                    s1_prod[k] <= PW'(s_axis.tdata[k*W +: W]) * PW'(coef_q);
                s1_user <= s_axis.tuser;
                s1_last <= in_is_last;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= rnd_data;
                s2_user <= s1_user;
                s2_last <= s1_last;
            end
        end
    end
endmodule

// File: tb/tb_norm_pipe.sv
// Self-checking bench for norm_pipe: vector table, scoreboard and frame-level sequences.
module tb_norm_pipe;
    localparam int W  = 16;
    localparam int L  = 2;
    localparam int UW = 2;
    localparam int CW = 24;
    localparam int FR = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          srst, s_axis_resetn, ap_start, cf_ap_done;
    logic          ap_done, ap_idle, ovf_sticky;
    logic [W-1:0]  norm_coef;
    logic [CW-1:0] frame_beats;

    norm_pipe_if #(.DW(L*W), .UW(UW)) s_if ();
    norm_pipe_if #(.DW(L*W), .UW(UW)) m_if ();

    norm_pipe #(
        .PIXEL_BIT_WIDTH(W), .FRAC_BITS(FR), .LANES(L), .USER_WIDTH(UW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .srst(srst), .s_axis_resetn(s_axis_resetn),
        .ap_start(ap_start), .cf_ap_done(cf_ap_done),
        .ap_done(ap_done), .ap_idle(ap_idle),
        .norm_coef(norm_coef), .frame_beats(frame_beats),
        .s_axis(s_if), .m_axis(m_if), .ovf_sticky(ovf_sticky)
    );

    typedef struct packed {
        logic [L*W-1:0] data;
        logic [UW-1:0]  user;
        logic           last;
    } beat_t;

    typedef struct {
        logic [W-1:0]  coef;
        logic [W-1:0]  l0, l1;
        logic [UW-1:0] user;
        logic [W-1:0]  e0, e1;
        logic          eovf;
    } vec_t;

    int checks = 0, failures = 0, cyc = 0;
    beat_t sb[$];
    logic [W-1:0]   coef_tb = '0;
    logic           cur_last = 1'b0, rand_rdy = 1'b0, lat_arm = 1'b0;
    logic           prev_done = 1'b0, stall_prev = 1'b0;
    logic [L*W-1:0] last_out = '0;
    beat_t          held;
    int out_beats = 0, first_in = -1, first_out = -1, last_hs_cyc = -10;
    vec_t vt[8];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [L*W-1:0] model(logic [L*W-1:0] din, logic [W-1:0] c);
        logic [L*W-1:0] res;
        longint unsigned p, r;
        res = '0;
        for (int k = 0; k < L; k++) begin
            p = longint'(din[k*W +: W]) * longint'(c);
            r = (p + (64'd1 << (FR - 1))) >> FR;
            res[k*W +: W] = (r > 64'd65535) ? 16'hFFFF : W'(r);
        end
        return res;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        m_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        beat_t e, t;
        if (stall_prev)
            chk("stall_hold", {m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast}, {1'b1, held});
        stall_prev = m_if.tvalid && !m_if.tready;
        held = {m_if.tdata, m_if.tuser, m_if.tlast};
        if (s_if.tvalid && s_if.tready) begin
            t.data = model(s_if.tdata, coef_tb);
            t.user = s_if.tuser;
            t.last = cur_last;
            sb.push_back(t);
            if (lat_arm && first_in < 0) first_in = cyc;
        end
        if (lat_arm && m_if.tvalid && first_out < 0) first_out = cyc;
        if (m_if.tvalid && m_if.tready) begin
            out_beats++;
            last_out = m_if.tdata;
            chk("sb_nonempty", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_data", m_if.tdata, e.data);
                chk("out_user", m_if.tuser, e.user);
                chk("out_last", m_if.tlast, e.last);
            end
            if (m_if.tlast) last_hs_cyc = cyc;
        end
        if (ap_done) begin
            chk("ap_done_timing", cyc - last_hs_cyc, 1);
            chk("ap_done_pulse", prev_done, 0);
        end
        prev_done = ap_done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [W-1:0] c, input logic [CW-1:0] n, input logic cf);
        ap_start = 1'b1; norm_coef = c; frame_beats = n; cf_ap_done = cf; coef_tb = c;
        tick();
        ap_start = 1'b0; cf_ap_done = 1'b0;
    endtask

    task automatic send_beat(input logic [L*W-1:0] d, input logic [UW-1:0] u, input logic last);
        bit ok = 1'b0;
        s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tuser = u; cur_last = last;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = s_if.tready;
            tick();
        end
        chk("in_accepted", ok, 1);
    endtask

    task automatic wait_done(input int limit);
        bit seen = 1'b0;
        s_if.tvalid = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            seen = ap_done;
        end
        chk("ap_done_seen", seen, 1);
        tick();
        chk("idle_after_done", ap_idle, 1);
    endtask

    task automatic check_reset_state(input string name);
        @(negedge clk);
        chk(name, {ap_idle, ap_done, s_if.tready, m_if.tvalid, m_if.tlast, ovf_sticky, m_if.tdata},
            {6'b100000, 32'h0});
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [L*W-1:0] d;
        srst = 1'b1; s_axis_resetn = 1'b1; ap_start = 1'b0; cf_ap_done = 1'b0;
        norm_coef = '0; frame_beats = '0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = 1'b0;

        vt[0] = '{16'd512,   16'd100,   16'd3,     2'd1, 16'd50,    16'd2,     1'b0};
        vt[1] = '{16'd1024,  16'd12345, 16'd0,     2'd2, 16'd12345, 16'd0,     1'b0};
        vt[2] = '{16'd1536,  16'd3,     16'd1,     2'd3, 16'd5,     16'd2,     1'b0};
        vt[3] = '{16'd1,     16'd512,   16'd511,   2'd0, 16'd1,     16'd0,     1'b0};
        vt[4] = '{16'd2048,  16'd30000, 16'd40000, 2'd1, 16'd60000, 16'd65535, 1'b1};
        vt[5] = '{16'd65535, 16'd1,     16'd0,     2'd2, 16'd64,    16'd0,     1'b0};
        vt[6] = '{16'd0,     16'd65535, 16'd65535, 2'd3, 16'd0,     16'd0,     1'b0};
        vt[7] = '{16'd2048,  16'd65535, 16'd32768, 2'd0, 16'd65535, 16'd65535, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        srst = 1'b0;
        sb.delete();
        check_reset_state("reset_state");

        for (int i = 0; i < 8; i++) begin
            start_frame(vt[i].coef, 24'd1, 1'b1);
            send_beat({vt[i].l1, vt[i].l0}, vt[i].user, 1'b1);
            wait_done(20);
            chk($sformatf("vec%0d_lane0", i), last_out[W-1:0], vt[i].e0);
            chk($sformatf("vec%0d_lane1", i), last_out[2*W-1:W], vt[i].e1);
            chk($sformatf("vec%0d_ovf", i), ovf_sticky, vt[i].eovf);
        end

        // Four-beat frame; an ap_start mid-frame must not disturb coef or count.
        out_beats = 0;
        start_frame(16'd512, 24'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send_beat({16'd3, 16'd100}, 2'(i), i == 3);
            if (i == 1) begin
                ap_start = 1'b1; norm_coef = 16'd1024; frame_beats = 24'd2;
            end else begin
                ap_start = 1'b0;
            end
        end
        wait_done(20);
        chk("frame4_beats", out_beats, 4);
        chk("frame4_lanes", last_out, {16'd2, 16'd50});

        lat_arm = 1'b1;
        start_frame(16'd1024, 24'd2, 1'b0);
        s_if.tvalid = 1'b1; s_if.tdata = {16'd7, 16'd9}; s_if.tuser = 2'd1; cur_last = 1'b0;
        bad = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (s_if.tready || m_if.tvalid) bad++;
            tick();
        end
        chk("wait_cf_gated", bad, 0);
        cf_ap_done = 1'b1;
        tick();
        cf_ap_done = 1'b0;
        send_beat({16'd7, 16'd9}, 2'd1, 1'b0);
        send_beat({16'd11, 16'd13}, 2'd2, 1'b1);
        wait_done(20);
        lat_arm = 1'b0;
        chk("first_out_latency", first_out - first_in, 2);

        out_beats = 0;
        rand_rdy = 1'b1;
        start_frame(16'd1024, 24'd1000, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            d = {16'($urandom), 16'($urandom)};
            send_beat(d, 2'($urandom), i == 999);
        end
        wait_done(3000);
        rand_rdy = 1'b0;
        chk("rand_beats", out_beats, 1000);
        chk("rand_sb_empty", sb.size(), 0);

        // Reset after the second of four beats: frame aborts, no trailing output.
        start_frame(16'd512, 24'd4, 1'b1);
        send_beat({16'd3, 16'd100}, 2'd0, 1'b0);
        send_beat({16'd3, 16'd100}, 2'd1, 1'b0);
        s_if.tvalid = 1'b0;
        srst = 1'b1;
        tick();
        srst = 1'b0;
        sb.delete();
        check_reset_state("midframe_reset");
        bad = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (m_if.tvalid || ap_done) bad++;
            tick();
        end
        chk("no_output_after_abort", bad, 0);
        out_beats = 0;
        start_frame(16'd512, 24'd4, 1'b1);
        for (int i = 0; i < 4; i++) send_beat({16'd40, 16'd1000}, 2'(i), i == 3);
        wait_done(20);
        chk("post_reset_beats", out_beats, 4);

        out_beats = 0;
        start_frame(16'd2048, 24'd0, 1'b1);
        send_beat({16'd0, 16'd65535}, 2'd3, 1'b1);
        wait_done(20);
        chk("zero_beats_count", out_beats, 1);
        chk("sat_lane0", last_out[W-1:0], 16'd65535);
        chk("ovf_set", ovf_sticky, 1);
        start_frame(16'd1024, 24'd1, 1'b1);
        chk("ovf_clear_on_start", ovf_sticky, 0);
        send_beat({16'd0, 16'd65535}, 2'd0, 1'b1);
        wait_done(20);
        chk("ovf_stays_clear", ovf_sticky, 0);

        start_frame(16'd2048, 24'd1, 1'b1);
        send_beat({16'd65535, 16'd1}, 2'd2, 1'b1);
        wait_done(20);
        chk("ovf_set2", ovf_sticky, 1);
        s_axis_resetn = 1'b0;
        tick();
        s_axis_resetn = 1'b1;
        check_reset_state("resetn_state");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/norm_pipe.md
NORM_PIPE -- requirements
Module: norm_pipe

Interface
REQ-001 Parameter PIXEL_BIT_WIDTH, default 16: bits per pixel lane, unsigned.
REQ-002 Parameter FRAC_BITS, default 10: fractional bits of norm_coef (UQ(PIXEL_BIT_WIDTH-FRAC_BITS).FRAC_BITS).
REQ-003 Parameter LANES, default 2: pixels per beat, range 1..8.
REQ-004 Parameter USER_WIDTH, default 2: sideband bits carried with each beat.
REQ-005 Parameter CNT_WIDTH, default 24: width of the beat counter.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  sole clock, all logic rising-edge.
REQ-008 srst  in  1  synchronous active-high reset.
REQ-009 s_axis_resetn  in  1  active-low synchronous stream reset, ORed with srst into the internal reset.
REQ-010 ap_start  in  1  single-cycle pulse that arms a frame.
REQ-011 cf_ap_done  in  1  upstream crop-filter done pulse; enables streaming.
REQ-012 ap_done  out  1  single-cycle pulse after the last output beat is accepted.
REQ-013 ap_idle  out  1  high in IDLE.
REQ-014 norm_coef  in  PIXEL_BIT_WIDTH  reciprocal coefficient, sampled on ap_start.
REQ-015 frame_beats  in  CNT_WIDTH  beats per frame, sampled on ap_start; 0 is treated as 1.
REQ-016 s_axis_tvalid/s_axis_tready  in/out  1  input handshake.
REQ-017 s_axis_tdata  in  LANES*PIXEL_BIT_WIDTH  lane k at bits [k*W +: W].
REQ-018 s_axis_tuser  in  USER_WIDTH  sideband.
REQ-019 m_axis_tvalid/m_axis_tready  out/in  1  output handshake.
REQ-020 m_axis_tdata  out  LANES*PIXEL_BIT_WIDTH; m_axis_tuser  out  USER_WIDTH; m_axis_tlast  out  1.
REQ-021 ovf_sticky  out  1  set when any lane saturated since the last ap_start.

Function
REQ-022 FSM states: IDLE, WAIT_CF, RUN, DRAIN. IDLE -ap_start-> WAIT_CF -cf_ap_done-> RUN -last input beat accepted-> DRAIN -last output beat accepted-> IDLE with ap_done=1 for that one cycle.
REQ-023 cf_ap_done coincident with ap_start in IDLE moves directly to RUN.
REQ-024 ap_start outside IDLE is ignored; latched coefficient and count remain unchanged.
REQ-025 s_axis_tready = (state==RUN) && pipeline enable; enable = !stage2_valid || m_axis_tready.
REQ-026 Two-stage pipeline: stage 1 registers the full 2W-bit product per lane; stage 2 registers the rounded, saturated result. Latency 2 cycles with no backpressure.
REQ-027 Per lane: r = (p + 2^(FRAC_BITS-1)) >> FRAC_BITS (round half up); if r > 2^W-1, output 2^W-1 and set ovf_sticky.
REQ-028 tuser travels with its beat through both stages.
REQ-029 m_axis_tlast is high on output beat number frame_beats, counted from 1.
REQ-030 When m_axis_tready=0 with stage 2 valid, every stage holds, and m_axis_tdata, tuser and tlast stay stable.
REQ-031 Input beat counter increments per accepted input beat and wraps to 0 only on frame completion, never mid-frame.
REQ-032 ovf_sticky clears on an ap_start that is accepted.

Reset
REQ-033 Internal reset: state=IDLE, all valids 0, counters 0, ovf_sticky=0, ap_done=0, ap_idle=1, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, data registers 0.
REQ-034 Reset mid-frame aborts the frame immediately: no ap_done and no further output beats.

Verification
REQ-035 W=16, FRAC=10, LANES=2, coef=512, frame_beats=4, lanes (100,3) -> out (50,2), tlast on beat 4, ap_done 1 cycle after beat 4 handshake.
REQ-036 coef=2048, lane 65535 -> out 65535, ovf_sticky=1; next ap_start -> ovf_sticky=0.
REQ-037 Data offered before cf_ap_done -> s_axis_tready=0 and no output; after cf_ap_done, first output 2 cycles after first input handshake.
REQ-038 Random m_axis_tready (50%), 1000 beats, coef=1024 -> out equals in, no loss or duplication, stable data while stalled.
REQ-039 srst at beat 2 of 4 -> outputs at reset values next cycle; a new frame then runs cleanly.
REQ-040 frame_beats=0 -> single beat with tlast=1, then ap_done.
